sram_controller_burst: RTL and testbench
========================================

// Module: sram_controller_burst
// PURPOSE
//  Parametrised SRAM controller between the ARM pipeline MEM stage and the off-chip 16-bit SRAM.
//  Each DATA_W-bit access is split into DATA_W/16 sequential halfword beats.
//  Each beat is held for a programmable number of wait states, with per-byte write masking.
//  ready is low while an access is in flight; the pipeline freezes on ~ready.
// PARAMETERS
//  DATA_W       32    CPU word width; multiple of 16 (32/64/128). BEATS = DATA_W/16
//  WAIT_CYCLES  2     extra cycles each beat is held (beat length = WAIT_CYCLES+1)
//  BASE_ADDR    1024  CPU byte address mapped to SRAM word 0
//  SRAM_AW      18    SRAM address width
// PORTS
//  clk        in   1         clock, all state on rising edge
//  rst        in   1         asynchronous, active-low reset
//  wrEn       in   1         write request, held until ready=1
//  rdEn       in   1         read request, held until ready=1
//  address    in   32        CPU byte address
//  writeData  in   DATA_W    write data
//  byteEn     in   DATA_W/8  write byte enables; bit i = byte i
//  readData   out  DATA_W    registered read result
//  ready      out  1         1 = idle or access complete this cycle
//  SRAM_DQ    io   16        SRAM data; driven only during write beats, else 'z
//  SRAM_ADDR  out  SRAM_AW   SRAM halfword address
//  SRAM_WE_N, SRAM_UB_N, SRAM_LB_N, SRAM_CE_N, SRAM_OE_N  out 1  SRAM strobes, active-low
// BEHAVIOUR
//  States: IDLE -> ACCESS -> DONE -> IDLE.
//  Reset (rst=0, async): state=IDLE, readData=0, beat/wait counters=0, DQ='z.
//    All SRAM_*_N=1, SRAM_ADDR=0, ready=1 (no request).
//  IDLE: ready = ~(wrEn|rdEn), combinational.
//    On a request, capture op, address, writeData and byteEn; go to ACCESS.
//    wrEn wins if wrEn and rdEn are both high.
//  Word base: wbase = ((address-BASE_ADDR) >> log2(DATA_W/8)) * BEATS.
//    Unsigned, modulo 2^SRAM_AW; no range error.
//  ACCESS: beat b = 0..BEATS-1, each held WAIT_CYCLES+1 cycles.
//    SRAM_ADDR = wbase + b; beat 0 = least-significant halfword.
//    CE_N=0 throughout ACCESS.
//    Write beat: WE_N=0, OE_N=1, DQ = writeData[16b+15:16b].
//      LB_N = ~byteEn[2b], UB_N = ~byteEn[2b+1].
//    Read beat: WE_N=1, OE_N=0, UB_N=LB_N=0.
//      On the last cycle of the beat, SRAM_DQ -> readData[16b+15:16b].
//  After the last cycle of the last beat -> DONE.
//  DONE: one cycle, ready=1, SRAM strobes inactive, next state IDLE.
//  Latency: request seen in cycle 0; ready=1 in cycle N+1, N = BEATS*(WAIT_CYCLES+1).
//    Defaults give N=6, so ready=1 in cycle 7.
//  Back-to-back: a request held in the cycle after DONE is accepted as new.
//  Request dropped mid-access: the access still completes; DONE is still entered.
//  Address/data changes mid-access are ignored; captured values are used.
//  readData updates only on read beats; it holds its value across writes and idle.
//  Reset mid-access aborts immediately: DQ released, strobes high, no partial readData kept.
// STRUCTURE
//  Package sram_ctrl_pkg: state encoding (IDLE/ACCESS/DONE), SRAM_DW=16, clog2 helper.
//  Sub-module sram_beat_timer: wait counter and beat counter.
//    Outputs beat index, beat_last_cycle and access_last.
//  Top: FSM, capture registers, address adder, DQ tri-state and strobe decode.
// TESTING
//  1. Reset: rst=0 mid-write -> all strobes=1, DQ='z, readData=0, ready=1 within the same cycle.
//  2. Write then read, defaults: write 0xDEADBEEF to 1028, byteEn=4'hF.
//     SRAM addr 2=0xBEEF, 3=0xDEAD; ready high exactly cycle 7.
//     Read of 1028 -> readData=0xDEADBEEF at cycle 7.
//  3. Byte mask: byteEn=4'b0100, data 0x11223344 at 1024.
//     Beat 0: LB_N=UB_N=1; beat 1: LB_N=0, UB_N=1.
//     Readback of 0xFFFFFFFF preset -> 0xFF22FFFF.
//  4. wrEn=rdEn=1 at 1032 -> write performed, WE_N=0, readData unchanged.
//  5. DATA_W=64, WAIT_CYCLES=0, read at 1024+8 -> SRAM_ADDR 4,5,6,7 on consecutive cycles.
//     ready=1 at cycle 5.
//  6. Drop rdEn after cycle 2 -> access completes, DONE still asserts ready=1 at cycle 7.
//     Back-to-back requests accepted in cycles 8 and 16.

Source files
------------

// File: rtl/sram_ctrl_pkg.sv
// Shared definitions for the burst SRAM controller.
//   state_t : controller FSM encoding (IDLE -> ACCESS -> DONE -> IDLE)
//   SRAM_DW : off-chip SRAM data width (one halfword per beat)
//   clog2   : ceiling log2 for elaboration-time width math
//   cnt_w   : counter width that holds 0..n-1, never narrower than one bit
package sram_ctrl_pkg;

    localparam int SRAM_DW = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

    function automatic int cnt_w(input int n);
        return (n > 1) ? clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sram_beat_timer.sv
// Beat sequencer for one SRAM burst.
// Counts WAIT_CYCLES+1 cycles per beat and BEATS beats per access while run
// is high; both counters return to zero whenever run is low.
// Ports:
//   clk, rst         clock, asynchronous active-low reset
//   run              high while the controller is in ACCESS
//   beat             current beat index (0 = least-significant halfword)
//   beat_last_cycle  final cycle of the current beat
//   access_last      final cycle of the final beat
module sram_beat_timer
    import sram_ctrl_pkg::*;
#(
    parameter int BEATS       = 2,
    parameter int WAIT_CYCLES = 2,
    localparam int BW         = cnt_w(BEATS),
    localparam int WW         = cnt_w(WAIT_CYCLES + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          run,
    output logic [BW-1:0] beat,
    output logic          beat_last_cycle,
    output logic          access_last
);

    logic [WW-1:0] wait_cnt;

    assign beat_last_cycle = run && (wait_cnt == WW'(WAIT_CYCLES));
    assign access_last     = beat_last_cycle && (beat == BW'(BEATS - 1));

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait_cnt <= '0;
            beat     <= '0;
        end else if (!run) begin
            wait_cnt <= '0;
            beat     <= '0;
        end else if (beat_last_cycle) begin
            wait_cnt <= '0;
            beat     <= access_last ? '0 : beat + 1'b1;
        end else begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/sram_controller_burst.sv
// Burst SRAM controller between the CPU MEM stage and a 16-bit async SRAM.
// A DATA_W access is split into DATA_W/16 halfword beats, each held for
// WAIT_CYCLES+1 cycles. ready drops while an access is in flight.
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   wrEn, rdEn               access requests, held until ready=1 (write wins)
//   address                  CPU byte address
//   writeData, byteEn        write data and per-byte enables
//   readData                 registered read result
//   ready                    idle with no request, or access done this cycle
//   SRAM_DQ                  bidirectional halfword bus, driven on write beats only
//   SRAM_ADDR                SRAM halfword address
//   SRAM_WE_N/UB_N/LB_N/CE_N/OE_N  active-low SRAM strobes
module sram_controller_burst
    import sram_ctrl_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int WAIT_CYCLES = 2,
    parameter int BASE_ADDR   = 1024,
    parameter int SRAM_AW     = 18
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wrEn,
    input  logic                rdEn,
    input  logic [31:0]         address,
    input  logic [DATA_W-1:0]   writeData,
    input  logic [DATA_W/8-1:0] byteEn,
    output logic [DATA_W-1:0]   readData,
    output logic                ready,
    inout  wire  [15:0]         SRAM_DQ,
    output logic [SRAM_AW-1:0]  SRAM_ADDR,
    output logic                SRAM_WE_N,
    output logic                SRAM_UB_N,
    output logic                SRAM_LB_N,
    output logic                SRAM_CE_N,
    output logic                SRAM_OE_N
);

    localparam int BEATS = DATA_W / SRAM_DW;
    localparam int BW    = cnt_w(BEATS);
    localparam int BSH   = clog2(DATA_W / 8);

    state_t               state, next_state;
    logic                 req;
    logic                 op_write;
    logic [SRAM_AW-1:0]   wbase, wbase_d;
    logic [DATA_W-1:0]    wdata_q;
    logic [DATA_W/8-1:0]  ben_q;
    logic [BW-1:0]        beat;
    logic                 beat_last_cycle, access_last;
    logic                 dq_oe;
    logic [SRAM_DW-1:0]   dq_out;

    assign req = wrEn | rdEn;

    // CPU word index scaled to halfwords; wraps modulo 2^SRAM_AW by design,
    // so addresses below BASE_ADDR simply alias to the top of the SRAM.
    assign wbase_d = SRAM_AW'((address - 32'(BASE_ADDR)) >> BSH) * SRAM_AW'(BEATS);

    sram_beat_timer #(
        .BEATS       (BEATS),
        .WAIT_CYCLES (WAIT_CYCLES)
    ) u_timer (
        .clk             (clk),
        .rst             (rst),
        .run             (state == ST_ACCESS),
        .beat            (beat),
        .beat_last_cycle (beat_last_cycle),
        .access_last     (access_last)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= ST_IDLE;
        else      state <= next_state;
    end

    // NOTE: every output of this block gets a default first, so no path
    // through the case leaves a signal unassigned and no latch is inferred.
    always_comb begin
        next_state = state;
        ready      = 1'b0;
        SRAM_ADDR  = '0;
        SRAM_WE_N  = 1'b1;
        SRAM_OE_N  = 1'b1;
        SRAM_CE_N  = 1'b1;
        SRAM_UB_N  = 1'b1;
        SRAM_LB_N  = 1'b1;
        dq_oe      = 1'b0;
        dq_out     = '0;
        case (state)
            ST_IDLE: begin
                ready = ~req;
                if (req) next_state = ST_ACCESS;
            end
            ST_ACCESS: begin
                SRAM_CE_N = 1'b0;
                SRAM_ADDR = wbase + SRAM_AW'(beat);
                if (op_write) begin
                    SRAM_WE_N = 1'b0;
                    dq_oe     = 1'b1;
                    dq_out    = wdata_q[{beat, 4'b0000} +: SRAM_DW];
                    SRAM_LB_N = ~ben_q[{beat, 1'b0}];
                    SRAM_UB_N = ~ben_q[{beat, 1'b1}];
                end else begin
                    SRAM_OE_N = 1'b0;
                    SRAM_UB_N = 1'b0;
                    SRAM_LB_N = 1'b0;
                end
                if (access_last) next_state = ST_DONE;
            end
            ST_DONE: begin
                ready      = 1'b1;
                next_state = ST_IDLE;
            end
            default: next_state = ST_IDLE;
        endcase
    end

    assign SRAM_DQ = dq_oe ? dq_out : {SRAM_DW{1'bz}};

    // NOTE: the capture registers are plain datapath flops, but they are
    // reset anyway so strobe decode never sees X before the first request.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op_write <= 1'b0;
            wbase    <= '0;
            wdata_q  <= '0;
            ben_q    <= '0;
        end else if (state == ST_IDLE && req) begin
            op_write <= wrEn;
            wbase    <= wbase_d;
            wdata_q  <= writeData;
            ben_q    <= byteEn;
        end
    end

    // Each read beat lands in its own halfword lane on the beat's last cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            readData <= '0;
        end else if (state == ST_ACCESS && !op_write && beat_last_cycle) begin
            readData[{beat, 4'b0000} +: SRAM_DW] <= SRAM_DQ;
        end
    end

endmodule

// File: tb/tb_sram_controller_burst.sv
// Directed bench for sram_controller_burst: a default-parameter instance
// (32-bit, 2 wait states) and a 64-bit zero-wait instance, each attached to a
// small behavioural SRAM. A released DQ bus reads back as 16'hFFFF because of
// the pullup on the default instance's bus.
module tb_sram_controller_burst;

    logic clk;
    logic rst;

    // ---------------- default instance ----------------
    logic        wr_en0, rd_en0;
    logic [31:0] addr0, wdata0, rdata0;
    logic [3:0]  ben0;
    logic        ready0;
    wire  [15:0] sram_dq0;
    logic [17:0] sram_addr0;
    logic        we0, ub0, lb0, ce0, oe0;
    logic [15:0] mem0 [0:255];

    pullup (sram_dq0);

    sram_controller_burst dut0 (
        .clk(clk), .rst(rst), .wrEn(wr_en0), .rdEn(rd_en0), .address(addr0),
        .writeData(wdata0), .byteEn(ben0), .readData(rdata0), .ready(ready0),
        .SRAM_DQ(sram_dq0), .SRAM_ADDR(sram_addr0), .SRAM_WE_N(we0),
        .SRAM_UB_N(ub0), .SRAM_LB_N(lb0), .SRAM_CE_N(ce0), .SRAM_OE_N(oe0)
    );

    assign sram_dq0 = (!ce0 && !oe0 && we0) ? mem0[sram_addr0[7:0]] : 16'hzzzz;

    always @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 256; i++) mem0[i] <= 16'hFFFF;
        end else if (!ce0 && !we0) begin
            if (!lb0) mem0[sram_addr0[7:0]][7:0]  <= sram_dq0[7:0];
            if (!ub0) mem0[sram_addr0[7:0]][15:8] <= sram_dq0[15:8];
        end
    end

    // ---------------- 64-bit, zero-wait instance ----------------
    logic        rd_en1;
    logic [31:0] addr1;
    logic [63:0] rdata1;
    logic        ready1;
    wire  [15:0] sram_dq1;
    logic [17:0] sram_addr1;
    logic        we1, ub1, lb1, ce1, oe1;
    logic [15:0] mem1 [0:255];

    sram_controller_burst #(.DATA_W(64), .WAIT_CYCLES(0)) dut1 (
        .clk(clk), .rst(rst), .wrEn(1'b0), .rdEn(rd_en1), .address(addr1),
        .writeData(64'h0), .byteEn(8'h00), .readData(rdata1), .ready(ready1),
        .SRAM_DQ(sram_dq1), .SRAM_ADDR(sram_addr1), .SRAM_WE_N(we1),
        .SRAM_UB_N(ub1), .SRAM_LB_N(lb1), .SRAM_CE_N(ce1), .SRAM_OE_N(oe1)
    );

    assign sram_dq1 = (!ce1 && !oe1 && we1) ? mem1[sram_addr1[7:0]] : 16'hzzzz;

    always @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 256; i++) mem1[i] <= 16'hA500 | 16'(i);
        end
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Per-cycle trace of the default instance; strobes packed {WE,OE,CE,UB,LB}.
    logic [17:0] tr_addr [0:39];
    logic [4:0]  tr_str  [0:39];

    task automatic run_access(input logic wr, input logic rd, input logic [31:0] addr,
                              input logic [31:0] wd, input logic [3:0] be,
                              input int drop_after, output int rdy_cyc);
        rdy_cyc = -1;
        wr_en0 = wr; rd_en0 = rd; addr0 = addr; wdata0 = wd; ben0 = be;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            tr_addr[c] = sram_addr0;
            tr_str[c]  = {we0, oe0, ce0, ub0, lb0};
            if (c == drop_after) begin
                wr_en0 = 1'b0; rd_en0 = 1'b0; addr0 = 32'h0; wdata0 = 32'h0;
            end
            if (ready0) begin
                rdy_cyc = c;
                break;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        wr_en0 = 1'b0; rd_en0 = 1'b0;
    endtask

    typedef struct {
        logic        wr;
        logic        rd;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  ben;
        logic [17:0] waddr;
        logic [15:0] exp_lo;
        logic [15:0] exp_hi;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t vecs [9];

    initial begin
        int          rc;
        logic [23:0] rvec;
        logic [17:0] d1_addr [0:19];
        logic [17:0] wa;

        vecs[0] = '{1'b1, 1'b0, 32'd1028, 32'hDEADBEEF, 4'hF,    18'd2,      16'hBEEF, 16'hDEAD, 32'h00000000};
        vecs[1] = '{1'b0, 1'b1, 32'd1028, 32'h00000000, 4'h0,    18'd2,      16'hBEEF, 16'hDEAD, 32'hDEADBEEF};
        vecs[2] = '{1'b1, 1'b0, 32'd1024, 32'h11223344, 4'b0100, 18'd0,      16'hFFFF, 16'hFF22, 32'hDEADBEEF};
        vecs[3] = '{1'b0, 1'b1, 32'd1024, 32'h00000000, 4'h0,    18'd0,      16'hFFFF, 16'hFF22, 32'hFF22FFFF};
        vecs[4] = '{1'b1, 1'b1, 32'd1032, 32'hCAFEF00D, 4'hF,    18'd4,      16'hF00D, 16'hCAFE, 32'hFF22FFFF};
        vecs[5] = '{1'b1, 1'b0, 32'd1036, 32'h55667788, 4'b1001, 18'd6,      16'hFF88, 16'h55FF, 32'hFF22FFFF};
        vecs[6] = '{1'b0, 1'b1, 32'd1036, 32'h00000000, 4'h0,    18'd6,      16'hFF88, 16'h55FF, 32'h55FFFF88};
        vecs[7] = '{1'b0, 1'b1, 32'd1032, 32'h00000000, 4'h0,    18'd4,      16'hF00D, 16'hCAFE, 32'hCAFEF00D};
        vecs[8] = '{1'b1, 1'b0, 32'd1020, 32'h0BADF00D, 4'hF,    18'h3FFFE,  16'hF00D, 16'h0BAD, 32'hCAFEF00D};

        rst = 1'b0;
        wr_en0 = 1'b0; rd_en0 = 1'b0; addr0 = 32'h0; wdata0 = 32'h0; ben0 = 4'h0;
        rd_en1 = 1'b0; addr1 = 32'h0;

        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset ready", ready0, 1'b1);
        check("reset strobes", tr_pack(we0, oe0, ce0, ub0, lb0), 5'b11111);
        check("reset readData", rdata0, 32'h0);
        check("reset SRAM_ADDR", sram_addr0, 18'h0);
        check("reset DQ released", sram_dq0, 16'hFFFF);
        @(posedge clk); #1;
        rst = 1'b1;

        // Table-driven accesses on the default instance.
        for (int i = 0; i < 9; i++) begin
            run_access(vecs[i].wr, vecs[i].rd, vecs[i].addr, vecs[i].wdata, vecs[i].ben, -1, rc);
            wa = vecs[i].waddr;
            check($sformatf("v%0d ready cycle", i), 64'(rc), 64'd7);
            check($sformatf("v%0d readData", i), rdata0, vecs[i].exp_rd);
            check($sformatf("v%0d beat0 addr", i), tr_addr[1], wa);
            check($sformatf("v%0d beat1 addr", i), tr_addr[4], wa + 18'd1);
            check($sformatf("v%0d mem lo", i), mem0[wa[7:0]], vecs[i].exp_lo);
            check($sformatf("v%0d mem hi", i), mem0[wa[7:0] + 8'd1], vecs[i].exp_hi);
            if (i == 1) begin
                check("read strobes beat0", tr_str[2], 5'b10000);
                check("done strobes idle", tr_str[7], 5'b11111);
            end
            if (i == 2) begin
                check("mask beat0 strobes", tr_str[1], 5'b01011);
                check("mask beat1 strobes", tr_str[4], 5'b01010);
            end
            if (i == 4) begin
                check("wr+rd does write", tr_str[1], 5'b01000);
            end
        end

        // Request and address dropped after cycle 2: access still completes.
        run_access(1'b0, 1'b1, 32'd1028, 32'h0, 4'h0, 2, rc);
        check("drop ready cycle", 64'(rc), 64'd7);
        check("drop readData", rdata0, 32'hDEADBEEF);
        check("drop beat1 addr", tr_addr[6], 18'd3);

        // Back-to-back: request held continuously -> DONE at 7, 15, 23.
        rd_en0 = 1'b1; addr0 = 32'd1036;
        for (int c = 0; c < 24; c++) begin
            @(negedge clk);
            rvec[c] = ready0;
            @(posedge clk); #1;
        end
        rd_en0 = 1'b0;
        check("b2b ready pattern", rvec, 24'h808080);
        check("b2b readData", rdata0, 32'h55FFFF88);

        // 64-bit zero-wait read at 1032 -> SRAM words 4..7, ready at cycle 5.
        rc = -1;
        rd_en1 = 1'b1; addr1 = 32'd1032;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            d1_addr[c] = sram_addr1;
            if (ready1) begin
                rc = c;
                break;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        rd_en1 = 1'b0;
        check("w64 ready cycle", 64'(rc), 64'd5);
        for (int k = 1; k <= 4; k++)
            check($sformatf("w64 addr cycle %0d", k), d1_addr[k], 18'(k + 3));
        check("w64 readData", rdata1, 64'hA507A506A505A504);

        // Reset asserted in the middle of a write beat.
        wr_en0 = 1'b1; addr0 = 32'd1028; wdata0 = 32'h12345678; ben0 = 4'hF;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("pre-reset write active", tr_pack(we0, oe0, ce0, ub0, lb0), 5'b01000);
        check("pre-reset DQ driven", sram_dq0, 16'h5678);
        #1;
        rst = 1'b0; wr_en0 = 1'b0;
        #1;
        check("abort strobes", tr_pack(we0, oe0, ce0, ub0, lb0), 5'b11111);
        check("abort DQ released", sram_dq0, 16'hFFFF);
        check("abort readData", rdata0, 32'h0);
        check("abort ready", ready0, 1'b1);
        check("abort SRAM_ADDR", sram_addr0, 18'h0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    function automatic logic [4:0] tr_pack(input logic we, input logic oe, input logic ce,
                                           input logic ub, input logic lb);
        return {we, oe, ce, ub, lb};
    endfunction

endmodule
